huffman_stream_packer: RTL
==========================

// Module: huffman_stream_packer
// PURPOSE
//  Parametrised successor to the fixed-table Huffman coder. Maps input symbols
//  through a run-time programmable code table and packs the variable-length
//  codes MSB-first into fixed OUT_W-bit words, with valid/ready handshakes on
//  both sides and a flush that emits the final partial word zero-padded.
//  It sits between the symbol source and the serial/byte output stage.
// PARAMETERS
//  SYM_W   7   symbol width; the table holds 2**SYM_W entries
//  CODE_W  10  maximum code length in bits
//  LEN_W   4   width of the length field; must satisfy 2**LEN_W > CODE_W
//  OUT_W   8   packed output word width
// PORTS
//  clk        in   1       single clock; all logic on its rising edge
//  reset      in   1       synchronous, active-high reset
//  cfg_we     in   1       table write strobe
//  cfg_addr   in   SYM_W   table entry to write
//  cfg_code   in   CODE_W  code, right-aligned; the low cfg_len bits are valid
//  cfg_len    in   LEN_W   code length; 0 marks the symbol as unmapped
//  in_valid   in   1       symbol offered
//  in_ready   out  1       symbol accepted when in_valid && in_ready
//  in_sym     in   SYM_W   input symbol
//  flush      in   1       pulse: drain residual bits as a padded last word
//  out_valid  out  1       packed word available
//  out_ready  in   1       word consumed when out_valid && out_ready
//  out_data   out  OUT_W   packed bits; the oldest bit is at out_data[OUT_W-1]
//  out_last   out  1       qualifies the word produced by a flush
//  flush_done out  1       one-cycle pulse when the flush completes
// BEHAVIOUR
//  - Reset (sync): state=IDLE, acc=0, cnt=0, all table entries set to len=0.
//    Outputs in_ready=0 during reset, then out_valid=0, out_last=0,
//    flush_done=0, out_data=0.
//  - Storage: accumulator acc of ACC_W=OUT_W+CODE_W-1 bits, left-aligned.
//    Bit count cnt ranges 0..ACC_W.
//  - Table writes: accepted on any cycle. Stored lengths above CODE_W are
//    clamped to CODE_W. Read is combinational at accept time; an accept in
//    the same cycle as a write to that address uses the OLD entry.
//  - FSM states: IDLE, APPEND, EMIT, PAD.
//    IDLE: in_ready=1 unless flush=1.
//      - flush has priority over in_valid.
//      - flush with cnt>0 -> PAD.
//      - flush with cnt==0 -> pulse flush_done next cycle; stay in IDLE.
//      - symbol accept: latch code/len of table[in_sym] -> APPEND.
//    APPEND: shift the len code bits into acc directly after the cnt valid
//      bits, MSB of the code first; cnt+=len.
//      - new cnt>=OUT_W -> EMIT, else -> IDLE.
//      - len==0: symbol dropped, acc/cnt unchanged -> IDLE.
//    EMIT: out_valid=1, out_data=acc[ACC_W-1 -: OUT_W], out_last=0.
//      - While out_ready=0, out_data is held stable.
//      - On handshake: acc<<=OUT_W, cnt-=OUT_W; cnt<OUT_W -> IDLE, else
//        stay in EMIT.
//    PAD: out_valid=1, out_last=1; out_data=residual bits, left-aligned,
//      zero-filled.
//      - On handshake: acc=0, cnt=0, flush_done=1 for one cycle -> IDLE.
//  - Latency: symbol accepted at cycle T; acc updated at T+1; a full word is
//    valid from T+2. Minimum spacing between accepts is 2 cycles.
//  - in_ready=0 in APPEND, EMIT and PAD. A flush outside IDLE is ignored;
//    the source must hold it until flush_done or until it sees IDLE.
//  - Invariant: cnt<OUT_W in IDLE, so an append can never overflow acc.
//  - Reset mid-operation: any pending word is discarded. out_valid drops in
//    the cycle after reset is sampled, and the table is cleared.
// TESTING (SYM_W=7, CODE_W=10, OUT_W=8)
//  1 Program 0x41=(2'b10,2) and 0x42=(3'b110,3). Send 41,42,41,42, then flush
//    -> out 0xB5 (last=0), then 0x80 (last=1), then a flush_done pulse.
//  2 Program 0x43=(10'h3FE,10); send 43,43 with out_ready=0 for 5 cycles.
//    -> out 0xFF is held stable while out_valid=1. After release: 0xFF, then
//    0xBF; flush -> 0xE0 with last=1.
//  3 Send an unprogrammed symbol (len 0). -> no out_valid, cnt unchanged,
//    in_ready high again 2 cycles after the accept.
//  4 Flush with cnt=0 -> no out_valid; flush_done=1 exactly one cycle later.
//  5 Assert reset while in EMIT with a word pending -> out_valid=0 next cycle.
//    A subsequent send of 0x41 plus flush emits nothing (table cleared).
//  6 Write 0x41=(3'b111,3) in the same cycle 0x41 (old entry 2'b10) is
//    accepted, then flush -> 0x80. The next 0x41 uses 3'b111.

Source files
------------

// File: rtl/huffman_stream_packer_if.sv
// Handshake and configuration bundle for huffman_stream_packer: table writes,
// symbol input stream and packed-word output stream.
interface huffman_stream_packer_if #(
  parameter int SYM_W  = 7,
  parameter int CODE_W = 10,
  parameter int LEN_W  = 4,
  parameter int OUT_W  = 8
);
  logic              cfg_we;
  logic [SYM_W-1:0]  cfg_addr;
  logic [CODE_W-1:0] cfg_code;
  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [SYM_W-1:0]  in_sym;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              flush_done;

  modport master (
    output cfg_we, cfg_addr, cfg_code, cfg_len,
    output in_valid, in_sym, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, flush_done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_code, cfg_len,
    input  in_valid, in_sym, flush, out_ready,
    output in_ready, out_valid, out_data, out_last, flush_done
  );
endinterface

// File: rtl/huffman_stream_packer.sv
// Programmable-table Huffman coder: looks up each symbol's variable-length
// code and packs codes MSB-first into OUT_W-bit words, with flush padding.
module huffman_stream_packer #(
  parameter int SYM_W  = 7,
  parameter int CODE_W = 10,
  parameter int LEN_W  = 4,
  parameter int OUT_W  = 8
) (
  input  logic clk,
  input  logic reset,
  huffman_stream_packer_if.slave bus
);
  localparam int ACC_W  = OUT_W + CODE_W - 1;
  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int DEPTH  = 2 ** SYM_W;

  localparam logic [CNT_W-1:0] OUT_W_C  = CNT_W'(OUT_W);
  localparam logic [LEN_W-1:0] CODE_W_L = LEN_W'(CODE_W);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_APPEND = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_PAD    = 2'd3;

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              flush_done_r;

  logic [CODE_W-1:0] tab_code [DEPTH];
  logic [LEN_W-1:0]  tab_len  [DEPTH];

  logic [CODE_W-1:0] code_p1;
  logic [LEN_W-1:0]  len_p1;

  logic              accept;
  logic [CNT_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_sub;
  logic              word_out;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > CODE_W_L) ? CODE_W_L : l;
  endfunction

  // Keeps only the low len bits, left-aligns them and places them at bit
  // offset pos from the top of the accumulator.
  function automatic logic [ACC_W-1:0] align_code(
    input logic [CODE_W-1:0] code,
    input logic [LEN_W-1:0]  len,
    input logic [CNT_W-1:0]  pos
  );
    logic [CODE_W-1:0] mask;
    logic [CODE_W-1:0] left;
    logic [ACC_W-1:0]  wide;
    mask = ~({CODE_W{1'b1}} << len);
    left = (code & mask) << (CODE_W_L - len);
    wide = {left, {(ACC_W-CODE_W){1'b0}}};
    return wide >> pos;
  endfunction

  assign accept   = bus.in_valid && bus.in_ready;
  assign cnt_sum  = cnt + CNT_W'(len_p1);
  assign cnt_sub  = cnt - OUT_W_C;
  assign word_out = (state == S_EMIT) || (state == S_PAD);

  assign bus.in_ready   = !reset && (state == S_IDLE) && !bus.flush;
  assign bus.out_valid  = word_out;
  assign bus.out_data   = word_out ? acc[ACC_W-1 -: OUT_W] : '0;
  assign bus.out_last   = (state == S_PAD);
  assign bus.flush_done = flush_done_r;

  // Code storage carries no reset; an entry only matters once its length is set.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) tab_code[bus.cfg_addr] <= bus.cfg_code;
  end

  // Stage p1: table entry latched at accept; the read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (accept) begin
      code_p1 <= tab_code[bus.in_sym];
      len_p1  <= tab_len[bus.in_sym];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      flush_done_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tab_len[i] <= '0;
    end else begin
      flush_done_r <= 1'b0;
      if (bus.cfg_we) tab_len[bus.cfg_addr] <= clamp_len(bus.cfg_len);
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            if (cnt != '0) state <= S_PAD;
            else           flush_done_r <= 1'b1;
          end else if (bus.in_valid) begin
            state <= S_APPEND;
          end
        end
        // Stage p2: merge the latched code into the accumulator.
        S_APPEND: begin
          if (len_p1 == '0) begin
            state <= S_IDLE;
          end else begin
            acc   <= acc | align_code(code_p1, len_p1, cnt);
            cnt   <= cnt_sum;
            state <= (cnt_sum >= OUT_W_C) ? S_EMIT : S_IDLE;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            acc   <= acc << OUT_W;
            cnt   <= cnt_sub;
            state <= (cnt_sub < OUT_W_C) ? S_IDLE : S_EMIT;
          end
        end
        default: begin
          if (bus.out_ready) begin
            acc          <= '0;
            cnt          <= '0;
            flush_done_r <= 1'b1;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
